router_register: RTL and testbench

Datapath register stage of the 1x3 router. Captures the header byte, passes payload bytes to the output FIFOs, and holds one byte aside while the FIFO is full. It also accumulates a running XOR parity over header and payload, then compares it against the packet's trailing parity byte to flag an error. It sits between the router input port and the FIFO write path, and is sequenced by the router FSM's state flags.

---
 rtl/router_register_pkg.sv | 24 ++
 rtl/router_register.sv | 112 +++++++++++
 tb/tb_router_register.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/router_register_pkg.sv
// Shared router definitions: byte width, header field layout and the reserved address.
// Imported by the datapath register stage and its bench.
package router_register_pkg;

   localparam int DATA_W       = 8;
   localparam int ADDR_W       = 2;
   localparam int HDR_LEN_MSB  = 7;
   localparam int HDR_LEN_LSB  = 2;
   localparam int HDR_ADDR_MSB = 1;
   localparam int HDR_ADDR_LSB = 0;

   localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

   typedef struct packed {
      logic [HDR_LEN_MSB-HDR_LEN_LSB:0] len;
      logic [ADDR_W-1:0]                addr;
   } hdr_t;

   // Only three output ports exist, so the top address value never gets a header latched.
   function automatic logic hdr_addr_ok(input logic [DATA_W-1:0] b);
      return b[HDR_ADDR_MSB:HDR_ADDR_LSB] != ADDR_INVALID;
   endfunction

endpackage

// File: rtl/router_register.sv
// Router datapath register: latches header, forwards payload to the FIFO with 1-cycle latency,
// parks one byte while the FIFO is full, and checks running XOR parity against the trailing parity byte.
module router_register
   import router_register_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              pkt_valid,
   input  logic              fifo_full,
   input  logic              rst_int_reg,
   input  logic              detect_add,
   input  logic              ld_state,
   input  logic              laf_state,
   input  logic              full_state,
   input  logic              lfd_state,
   input  logic [DATA_W-1:0] data_in,
   output logic              parity_done,
   output logic              low_pkt_valid,
   output logic              err,
   output logic [DATA_W-1:0] dout
);

   logic [DATA_W-1:0] hdr_q, hdr_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic [DATA_W-1:0] int_par_q, int_par_d;
   logic [DATA_W-1:0] pkt_par_q, pkt_par_d;
   logic              lpv_q, lpv_d;
   logic              pd_q, pd_d;
   logic              err_q, err_d;
   logic              par_byte_take;

   // The parity byte is the first byte presented with pkt_valid low while loading into a non-full FIFO.
   assign par_byte_take = ld_state && !fifo_full && !pkt_valid;

   always_comb begin
      hdr_d     = hdr_q;
      hold_d    = hold_q;
      dout_d    = dout_q;
      int_par_d = int_par_q;
      pkt_par_d = pkt_par_q;
      lpv_d     = lpv_q;
      pd_d      = pd_q;
      err_d     = err_q;

      if (detect_add && pkt_valid && hdr_addr_ok(data_in))
         hdr_d = data_in;

      if (lfd_state)
         dout_d = hdr_q;
      else if (ld_state && !fifo_full)
         dout_d = data_in;
      else if (ld_state)
         hold_d = data_in;
      else if (laf_state)
         dout_d = hold_q;

      if (rst_int_reg)
         lpv_d = 1'b0;
      else if (ld_state && !pkt_valid)
         lpv_d = 1'b1;

      // Bytes re-presented while waiting on a full FIFO were already counted once.
      if (detect_add)
         int_par_d = '0;
      else if (lfd_state && pkt_valid)
         int_par_d = int_par_q ^ hdr_q;
      else if (ld_state && pkt_valid && !full_state)
         int_par_d = int_par_q ^ data_in;

      if (detect_add)
         pkt_par_d = '0;
      else if (par_byte_take)
         pkt_par_d = data_in;

      if (detect_add)
         pd_d = 1'b0;
      else if (par_byte_take || (laf_state && lpv_q && !pd_q))
         pd_d = 1'b1;

      if (pd_q)
         err_d = (int_par_q != pkt_par_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hdr_q     <= '0;
         hold_q    <= '0;
         dout_q    <= '0;
         int_par_q <= '0;
         pkt_par_q <= '0;
         lpv_q     <= 1'b0;
         pd_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         hdr_q     <= hdr_d;
         hold_q    <= hold_d;
         dout_q    <= dout_d;
         int_par_q <= int_par_d;
         pkt_par_q <= pkt_par_d;
         lpv_q     <= lpv_d;
         pd_q      <= pd_d;
         err_q     <= err_d;
      end
   end

   assign dout          = dout_q;
   assign parity_done   = pd_q;
   assign low_pkt_valid = lpv_q;
   assign err           = err_q;

endmodule

// File: tb/tb_router_register.sv
// Bench for router_register: sequences packets the way the router FSM would and
// predicts dout/status from packet-level rules (header, payload list, XOR parity).
module tb_router_register;
   import router_register_pkg::*;

   logic              clk = 1'b0;
   logic              rst, pkt_valid, fifo_full, rst_int_reg;
   logic              detect_add, ld_state, laf_state, full_state, lfd_state;
   logic [DATA_W-1:0] data_in, dout;
   logic              parity_done, low_pkt_valid, err;

   int checks   = 0;
   int failures = 0;

   // Packet-level expectations
   logic [DATA_W-1:0] exp_hdr;
   logic [DATA_W-1:0] exp_dout;
   logic              exp_err;

   always #5 clk = ~clk;

   router_register dut (
      .clk          (clk),
      .rst          (rst),
      .pkt_valid    (pkt_valid),
      .fifo_full    (fifo_full),
      .rst_int_reg  (rst_int_reg),
      .detect_add   (detect_add),
      .ld_state     (ld_state),
      .laf_state    (laf_state),
      .full_state   (full_state),
      .lfd_state    (lfd_state),
      .data_in      (data_in),
      .parity_done  (parity_done),
      .low_pkt_valid(low_pkt_valid),
      .err          (err),
      .dout         (dout)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rst         = 1'b0;
      pkt_valid   = 1'b0;
      fifo_full   = 1'b0;
      rst_int_reg = 1'b0;
      detect_add  = 1'b0;
      ld_state    = 1'b0;
      laf_state   = 1'b0;
      full_state  = 1'b0;
      lfd_state   = 1'b0;
      data_in     = 8'($urandom);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      idle();
      rst = 1'b1;
      tick();
      exp_hdr  = '0;
      exp_dout = '0;
      exp_err  = 1'b0;
      check({tag, "_dout"}, dout, 8'd0);
      check({tag, "_pd"}, 8'(parity_done), 8'd0);
      check({tag, "_lpv"}, 8'(low_pkt_valid), 8'd0);
      check({tag, "_err"}, 8'(err), 8'd0);
   endtask

   // detect + lfd; returns the parity the packet should carry so far
   task automatic start_pkt(input logic [7:0] hdr_byte, output logic [7:0] par);
      idle();
      detect_add = 1'b1;
      pkt_valid  = 1'b1;
      data_in    = hdr_byte;
      tick();
      if (hdr_byte[HDR_ADDR_MSB:HDR_ADDR_LSB] != ADDR_INVALID)
         exp_hdr = hdr_byte;
      check("detect_pd_clr", 8'(parity_done), 8'd0);
      check("detect_dout_hold", dout, exp_dout);
      check("detect_err_hold", 8'(err), 8'(exp_err));

      idle();
      lfd_state = 1'b1;
      pkt_valid = 1'b1;
      tick();
      exp_dout = exp_hdr;
      check("lfd_dout_hdr", dout, exp_hdr);
      par = exp_hdr;
   endtask

   // full_mode: 0 never full, 1 random stalls, 2 first byte is 0x55 and stalls
   task automatic send_byte(input logic [7:0] b, input bit stall);
      if (stall) begin
         idle();
         ld_state  = 1'b1;
         pkt_valid = 1'b1;
         fifo_full = 1'b1;
         data_in   = b;
         tick();
         check("full_dout_hold", dout, exp_dout);
         for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
            // source keeps re-presenting the stalled byte while the FSM waits
            idle();
            ld_state   = 1'b1;
            full_state = 1'b1;
            fifo_full  = 1'b1;
            pkt_valid  = 1'b1;
            data_in    = b;
            tick();
            check("fullst_dout_hold", dout, exp_dout);
         end
         idle();
         laf_state = 1'b1;
         pkt_valid = 1'b1;
         tick();
         check("laf_dout", dout, b);
      end else begin
         idle();
         ld_state  = 1'b1;
         pkt_valid = 1'b1;
         data_in   = b;
         tick();
         check("ld_dout", dout, b);
      end
      check("load_lpv_low", 8'(low_pkt_valid), 8'd0);
      exp_dout = b;
   endtask

   task automatic run_pkt(input logic [7:0] hdr_byte, input bit bad, input int full_mode);
      logic [7:0] par, b, pbyte;
      int n;
      n = int'(hdr_byte[HDR_LEN_MSB:HDR_LEN_LSB]);
      start_pkt(hdr_byte, par);
      for (int i = 0; i < n; i++) begin
         b = (full_mode == 2 && i == 0) ? 8'h55 : 8'($urandom);
         par ^= b;
         send_byte(b, (full_mode == 2 && i == 0) || (full_mode == 1 && $urandom_range(0, 3) == 0));
      end

      pbyte = bad ? (par ^ 8'h01) : par;
      idle();
      ld_state = 1'b1;
      data_in  = pbyte;
      tick();
      exp_dout = pbyte;
      check("par_dout", dout, pbyte);
      check("par_pd", 8'(parity_done), 8'd1);
      check("par_lpv", 8'(low_pkt_valid), 8'd1);
      check("par_err_hold", 8'(err), 8'(exp_err));

      idle();
      tick();
      exp_err = bad;
      check("err_eval", 8'(err), 8'(exp_err));
      check("post_pd", 8'(parity_done), 8'd1);
      check("post_lpv", 8'(low_pkt_valid), 8'd1);

      idle();
      rst_int_reg = 1'b1;
      tick();
      check("rstint_lpv", 8'(low_pkt_valid), 8'd0);
      check("rstint_pd", 8'(parity_done), 8'd1);
      check("rstint_err", 8'(err), 8'(exp_err));
      check("rstint_dout", dout, exp_dout);
   endtask

   initial begin
      hdr_t h;
      logic [7:0] par;

      do_reset("reset");

      run_pkt(8'h3A, 1'b0, 0);
      run_pkt(8'h3A, 1'b1, 0);
      run_pkt(8'h3A, 1'b0, 2);
      run_pkt(8'h3B, 1'b0, 0);
      run_pkt(8'h3B, 1'b1, 1);

      // abort a packet partway through
      start_pkt(8'h16, par);
      send_byte(8'hA5, 1'b0);
      send_byte(8'h5A, 1'b1);
      do_reset("midrst");

      for (int p = 0; p < 40; p++) begin
         h.len  = 6'($urandom_range(0, 20));
         h.addr = 2'($urandom_range(0, 3));
         run_pkt(h, 1'($urandom_range(0, 1)), 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
